// File: rtl/axis_dwidth_down_syn_pkg.sv
// axis_dwidth_down_syn_pkg: shared width helpers for the stream blocks
package axis_dwidth_down_syn_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axis_dwidth_down_syn.sv
// axis_dwidth_down_syn: splits each wide AXIS word into RATIO narrow slices
module axis_dwidth_down_syn
  import axis_dwidth_down_syn_pkg::*;
#(
  parameter int S_DATA_WIDTH = 36,
  parameter int RATIO = 4,
  parameter bit LSB_FIRST = 1'b1,
  localparam int M_DATA_WIDTH = S_DATA_WIDTH / RATIO
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_payload,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [M_DATA_WIDTH-1:0] m_payload,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last
);
  localparam int CNT_WIDTH = clog2(RATIO) < 1 ? 1 : clog2(RATIO);
  if (RATIO < 1 || S_DATA_WIDTH % RATIO != 0) begin : g_bad_ratio
    $fatal(1, "S_DATA_WIDTH must be a positive multiple of RATIO");
  end
  logic [S_DATA_WIDTH-1:0] hold_reg;
  logic                    hold_valid;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [CNT_WIDTH-1:0]    idx;
  logic                    take;
  // slice select and handshakes; s_ready depends only on held state and m_ready
  always_comb begin
    idx = LSB_FIRST ? cnt : CNT_WIDTH'(RATIO - 1) - cnt;
    m_valid = hold_valid;
    m_last = hold_valid && (cnt == CNT_WIDTH'(RATIO - 1));
    m_payload = M_DATA_WIDTH'(hold_reg >> (int'(idx) * M_DATA_WIDTH));
    take = hold_valid && m_ready;
    s_ready = !hold_valid || (take && m_last);
  end
  // holding register reloads only when empty or on its final slice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_reg <= '0;
      hold_valid <= 1'b0;
      cnt <= '0;
    end else begin
      if (s_valid && s_ready) hold_reg <= s_payload;
      hold_valid <= (s_valid && s_ready) || (hold_valid && !(take && m_last));
      if (take) cnt <= m_last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_dwidth_down_syn.sv
// tb_axis_dwidth_down_syn: randomized scoreboard bench for three configurations
module tb_axis_dwidth_down_syn;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [35:0] s_payload = '0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;
  logic [8:0]  mp_lsb, mp_msb;
  logic [35:0] mp_r1;
  logic        sr [3];
  logic        mv [3];
  logic        ml [3];
  logic [35:0] mp [3];
  int checks = 0;
  int errors = 0;
  int acc0 = 0;
  int ratio [3] = '{4, 4, 1};
  bit lsb [3] = '{1'b1, 1'b0, 1'b1};
  logic [35:0] q0 [$];
  logic [35:0] q1 [$];
  logic [35:0] q2 [$];
  logic [35:0] w = 36'h123456789;
  logic [8:0] exp_lsb [4] = '{9'h189, 9'h0B3, 9'h0D1, 9'h024};
  logic [8:0] exp_msb [4] = '{9'h024, 9'h0D1, 9'h0B3, 9'h189};

  always #5 clk = ~clk;

  axis_dwidth_down_syn dut_lsb (.clk(clk), .rst(rst), .s_payload(s_payload), .s_valid(s_valid),
    .s_ready(sr[0]), .m_payload(mp_lsb), .m_valid(mv[0]), .m_ready(m_ready), .m_last(ml[0]));
  axis_dwidth_down_syn #(.LSB_FIRST(1'b0)) dut_msb (.clk(clk), .rst(rst), .s_payload(s_payload),
    .s_valid(s_valid), .s_ready(sr[1]), .m_payload(mp_msb), .m_valid(mv[1]), .m_ready(m_ready),
    .m_last(ml[1]));
  axis_dwidth_down_syn #(.RATIO(1)) dut_r1 (.clk(clk), .rst(rst), .s_payload(s_payload),
    .s_valid(s_valid), .s_ready(sr[2]), .m_payload(mp_r1), .m_valid(mv[2]), .m_ready(m_ready),
    .m_last(ml[2]));

  assign mp[0] = 36'(mp_lsb);
  assign mp[1] = 36'(mp_msb);
  assign mp[2] = mp_r1;

  function automatic logic [35:0] slice(input int k, input logic [35:0] v, input int i);
    int mw;
    int j;
    logic [35:0] mask;
    mw = 36 / ratio[k];
    j = lsb[k] ? i : ratio[k] - 1 - i;
    mask = (mw == 36) ? '1 : ((36'h1 << mw) - 36'h1);
    return (v >> (j * mw)) & mask;
  endfunction

  task automatic chk(input string n, input int k, input logic [35:0] a, input logic [35:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d] got %h want %h at %0t", n, k, a, e, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return k == 0 ? q0.size() : k == 1 ? q1.size() : q2.size();
  endfunction

  function automatic logic [35:0] qfront(input int k);
    return k == 0 ? q0[0] : k == 1 ? q1[0] : q2[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(q0.pop_front());
    else if (k == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endtask

  task automatic qpush(input int k, input logic [35:0] v);
    if (k == 0) q0.push_back(v);
    else if (k == 1) q1.push_back(v);
    else q2.push_back(v);
  endtask

  logic        prev_stall = 1'b0;
  logic [35:0] prev_mp = '0;

  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
      q2.delete();
    end
    if (prev_stall && rst) chk("stall_stable", 0, mp[0], prev_mp);
    prev_stall = rst && mv[0] && !m_ready;
    prev_mp = mp[0];
    for (int k = 0; k < 3; k++) begin
      logic esr;
      int n;
      n = qsize(k);
      esr = (n == 0) || (m_ready && n == 1);
      chk("s_ready", k, 36'(sr[k]), 36'(esr));
      chk("m_valid", k, 36'(mv[k]), 36'(n > 0));
      chk("m_last", k, 36'(ml[k]), 36'(n == 1 || (n > 0 && ratio[k] == 1)));
      if (n > 0) chk("m_payload", k, mp[k], qfront(k));
      if (!rst) chk("rst_payload", k, mp[k], 36'h0);
      if (rst) begin
        if (n > 0 && m_ready) qpop(k);
        if (s_valid && esr) begin
          for (int i = 0; i < ratio[k]; i++) qpush(k, slice(k, s_payload, i));
          if (k == 0) acc0++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accs;
    int vals;
    int budget;
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_payload = 36'hFEDCBA987;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_m_valid", k, 36'(mv[k]), 36'h0);
      chk("reset_s_ready", k, 36'(sr[k]), 36'h1);
      chk("reset_payload", k, mp[k], 36'h0);
    end
    step();
    s_valid = 1'b0;
    rst = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("model_lsb", i, slice(0, w, i), 36'(exp_lsb[i]));
      chk("model_msb", i, slice(1, w, i), 36'(exp_msb[i]));
    end
    s_payload = w;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lit_lsb", i, mp[0], 36'(exp_lsb[i]));
      chk("lit_msb", i, mp[1], 36'(exp_msb[i]));
      chk("lit_last", i, 36'(ml[0]), 36'(i == 3));
      chk("lit_r1_valid", i, 36'(mv[2]), 36'(i == 0));
      if (i == 0) chk("lit_r1_payload", i, mp[2], w);
    end
    step();
    step();
    accs = 0;
    vals = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (c == 12) s_valid = 1'b0;
      s_payload = {$urandom, $urandom};
      @(negedge clk);
      if (s_valid && sr[0]) accs++;
      if (c >= 1 && mv[0]) vals++;
      step();
    end
    chk("b2b_accepts", 0, 36'(accs), 36'd3);
    chk("b2b_valid_cycles", 0, 36'(vals), 36'd12);
    acc0 = 0;
    budget = 0;
    while (acc0 < 1000 && budget < 40000) begin
      m_ready = $urandom_range(0, 99) < 60;
      s_valid = $urandom_range(0, 99) < 70;
      s_payload = {$urandom, $urandom};
      step();
      budget++;
    end
    chk("random_budget", 0, 36'(acc0 >= 1000), 36'h1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    s_payload = w;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("mid_slice0", 0, mp[0], 36'(exp_lsb[0]));
    @(negedge clk);
    chk("mid_slice1", 0, mp[0], 36'(exp_lsb[1]));
    step();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_discard", i, 36'(mv[0]), 36'h0);
    end
    step();
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_slice0", 0, mp[0], 36'(exp_lsb[0]));
    for (int i = 0; i < 6; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
